// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: mode encoding, field-select bit positions and divider sizing shared by the stopwatch control files
package stopwatch_pkg;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_t;
    localparam int SEL_MIN = 1;
    localparam int SEL_SEC = 0;
    function automatic int div_width(input int hz);
        return (hz > 2) ? $clog2(hz) : 1;
    endfunction
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: board-side buttons/switches and counter-side strobes of the stopwatch control block
//   master: the control block (takes raw inputs, drives strobes/levels)
//   slave : board and minutes/seconds counter side
interface stopwatch_ctrl_if;
    logic       btn_pause;
    logic       btn_reset;
    logic       sw_adj;
    logic [1:0] sw_sel;
    logic       cnt_en;
    logic       adj_en;
    logic [1:0] adj_sel;
    logic       is_adj;
    logic       paused;
    logic       clear;
    logic       blink;
    modport master (
        input  btn_pause, btn_reset, sw_adj, sw_sel,
        output cnt_en, adj_en, adj_sel, is_adj, paused, clear, blink
    );
    modport slave (
        output btn_pause, btn_reset, sw_adj, sw_sel,
        input  cnt_en, adj_en, adj_sel, is_adj, paused, clear, blink
    );
endinterface

// File: rtl/stopwatch_debounce.sv
// stopwatch_debounce: 2-flop synchroniser, stability filter and registered rising-edge press pulse for one button
//   clk, rst : clock and synchronous active-high reset
//   i_btn    : raw asynchronous button level
//   o_press  : one-cycle pulse when the filtered level rises
module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_stable_q;
    logic          r_press;
    logic          w_diff;
    logic          w_done;
    assign w_diff = r_sync[1] != r_stable;
    // the level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle
    assign w_done = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_btn};
            r_cnt      <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
            r_stable   <= w_done ? r_sync[1] : r_stable;
            r_stable_q <= r_stable;
            r_press    <= r_stable && !r_stable_q;
        end
    end
    assign o_press = r_press;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button debounce, switch sync, 1 Hz / 2 Hz enable divider and RUN/PAUSED/ADJUST mode machine
//   clk, rst : clock and synchronous active-high reset
//   bus      : master side of stopwatch_ctrl_if (raw buttons/switches in; cnt_en, adj_en,
//              adj_sel, is_adj, paused, clear, blink out, all driven from flops)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic               clk,
    input logic               rst,
    stopwatch_ctrl_if.master  bus
);
    localparam int            DW       = div_width(CLK_HZ);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_HZ / 2 - 1);
    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div;
    logic [1:0]    r_adj_sync;
    logic [1:0]    r_sel_s1;
    logic [1:0]    r_sel_s2;
    logic          r_cnt_en;
    logic          r_adj_en;
    logic          r_is_adj;
    logic          r_paused;
    logic          r_blink;
    logic          w_pause_press;
    logic          w_clear;
    logic          w_adj;
    logic          w_tick1;
    logic          w_tick2;
    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn_pause),
        .o_press (w_pause_press)
    );
    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn_reset),
        .o_press (w_clear)
    );
    assign w_adj   = r_adj_sync[1];
    assign w_tick1 = r_div == DIV_LAST;
    assign w_tick2 = w_tick1 || (r_div == DIV_HALF);
    always_comb begin
        w_next = r_state;
        w_div  = r_div;
        if (r_state != ADJUST && w_adj)
            w_next = ADJUST;
        else if (r_state == ADJUST && !w_adj)
            w_next = PAUSED;
        else if (w_pause_press && !w_clear && r_state != ADJUST)
            w_next = (r_state == RUN) ? PAUSED : RUN;
        // restart the second on any mode change or clear so a resumed count is a full period
        if (w_next != r_state || w_clear)
            w_div = '0;
        else if (r_state != PAUSED)
            w_div = w_tick1 ? '0 : r_div + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_div      <= '0;
            r_adj_sync <= '0;
            r_sel_s1   <= '0;
            r_sel_s2   <= '0;
            r_cnt_en   <= 1'b0;
            r_adj_en   <= 1'b0;
            r_is_adj   <= 1'b0;
            r_paused   <= 1'b0;
            r_blink    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_div      <= w_div;
            r_adj_sync <= {r_adj_sync[0], bus.sw_adj};
            r_sel_s1   <= bus.sw_sel;
            r_sel_s2   <= r_sel_s1;
            r_cnt_en   <= w_tick1 && r_state == RUN && !w_clear;
            r_adj_en   <= w_tick2 && r_state == ADJUST;
            r_is_adj   <= w_next == ADJUST;
            r_paused   <= w_next == PAUSED;
            r_blink    <= (w_next == ADJUST) && (r_blink ^ (w_tick2 && r_state == ADJUST));
        end
    end
    assign bus.cnt_en  = r_cnt_en;
    assign bus.adj_en  = r_adj_en;
    assign bus.adj_sel = {r_sel_s2[SEL_MIN], r_sel_s2[SEL_SEC]};
    assign bus.is_adj  = r_is_adj;
    assign bus.paused  = r_paused;
    assign bus.clear   = w_clear;
    assign bus.blink   = r_blink;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: self-checking bench for stopwatch_ctrl with CLK_HZ=20, DEBOUNCE_CYCLES=4
module tb_stopwatch_ctrl;
    localparam int         HZ    = 20;
    localparam int         DB    = 4;
    localparam logic [2:0] K_CNT = 3'b001;
    localparam logic [2:0] K_ADJ = 3'b010;
    localparam logic [2:0] K_CLR = 3'b100;
    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } ev_t;
    typedef struct {
        logic [1:0] sel;
        logic [1:0] exp;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    ev_t        q[$];
    ev_t        mon_ev;
    logic [2:0] mon_act;
    vec_t       vt[6];
    logic [1:0] prev;
    logic [7:0] w_outs;
    stopwatch_ctrl_if bus();
    stopwatch_ctrl #(.CLK_HZ(HZ), .DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    assign w_outs = {bus.clear, bus.adj_en, bus.cnt_en, bus.is_adj, bus.paused, bus.blink, bus.adj_sel};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask
    task automatic push(input int c, input logic [2:0] k);
        q.push_back('{c, k});
    endtask
    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, a, e);
        end
    endtask
    task automatic chk8(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
        end
    endtask
    // strobe scoreboard: every cnt_en/adj_en/clear must match the next scheduled event exactly
    always @(negedge clk) begin
        mon_act = {bus.clear, bus.adj_en, bus.cnt_en};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL strobe_missed cyc=%0d kind=%b due=%0d", cyc, q[0].kind, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_ev = q.pop_front();
            checks++;
            if (mon_act !== mon_ev.kind) begin
                failures++;
                $display("FAIL strobe cyc=%0d got=%b exp=%b", cyc, mon_act, mon_ev.kind);
            end
        end else if (mon_act !== 3'b000) begin
            checks++;
            failures++;
            $display("FAIL strobe_unexpected cyc=%0d got=%b exp=000", cyc, mon_act);
        end
    end
    initial begin
        vt = '{'{2'b01, 2'b01}, '{2'b11, 2'b11}, '{2'b00, 2'b00},
               '{2'b10, 2'b10}, '{2'b01, 2'b01}, '{2'b00, 2'b00}};
        bus.btn_pause = 1'b0;
        bus.btn_reset = 1'b0;
        bus.sw_adj    = 1'b0;
        bus.sw_sel    = 2'b00;
        wait_to(2);
        chk8("reset_outs", w_outs, 8'h00);
        wait_to(3);
        rst = 1'b0;
        for (int t = 23; t <= 83; t += 20) push(t, K_CNT);
        wait_to(30);
        prev = 2'b00;
        foreach (vt[i]) begin
            bus.sw_sel = vt[i].sel;
            @(negedge clk);
            chk8("adj_sel_hold", 8'(bus.adj_sel), 8'(prev));
            @(negedge clk);
            chk8("adj_sel_sync", 8'(bus.adj_sel), 8'(vt[i].exp));
            prev = vt[i].exp;
        end
        wait_to(60);
        chk8("run_levels", w_outs, 8'h00);
        wait_to(65);
        bus.btn_pause = 1'b1;
        wait_to(68);
        bus.btn_pause = 1'b0;
        wait_to(69);
        bus.btn_pause = 1'b1;
        wait_to(72);
        bus.btn_pause = 1'b0;
        wait_to(85);
        chk1("bounce_no_pause", bus.paused, 1'b0);
        bus.btn_pause = 1'b1;
        wait_to(92);
        chk1("pause_not_yet", bus.paused, 1'b0);
        wait_to(93);
        chk1("pause_enter", bus.paused, 1'b1);
        wait_to(95);
        bus.btn_pause = 1'b0;
        wait_to(110);
        chk1("paused_hold", bus.paused, 1'b1);
        bus.btn_pause = 1'b1;
        push(138, K_CNT);
        push(158, K_CNT);
        wait_to(117);
        chk1("resume_not_yet", bus.paused, 1'b1);
        wait_to(118);
        chk1("resume", bus.paused, 1'b0);
        wait_to(120);
        bus.btn_pause = 1'b0;
        wait_to(160);
        bus.sw_sel = 2'b10;
        wait_to(165);
        bus.sw_adj = 1'b1;
        for (int t = 178; t <= 198; t += 10) push(t, K_ADJ);
        wait_to(167);
        chk1("adj_not_yet", bus.is_adj, 1'b0);
        wait_to(168);
        chk1("adj_enter", bus.is_adj, 1'b1);
        wait_to(170);
        chk8("adj_sel_min", 8'(bus.adj_sel), 8'h02);
        wait_to(178);
        chk1("blink_1", bus.blink, 1'b1);
        wait_to(180);
        bus.btn_pause = 1'b1;
        wait_to(188);
        chk1("blink_2", bus.blink, 1'b0);
        wait_to(190);
        chk1("adj_ignores_pause", bus.is_adj, 1'b1);
        chk1("adj_not_paused", bus.paused, 1'b0);
        bus.btn_pause = 1'b0;
        wait_to(198);
        chk1("blink_3", bus.blink, 1'b1);
        wait_to(202);
        bus.sw_adj = 1'b0;
        wait_to(204);
        chk1("adj_exit_not_yet", bus.is_adj, 1'b1);
        wait_to(205);
        chk1("adj_exit_blink", bus.blink, 1'b0);
        chk1("adj_exit_paused", bus.paused, 1'b1);
        chk1("adj_exit_is_adj", bus.is_adj, 1'b0);
        wait_to(210);
        bus.btn_pause = 1'b1;
        push(238, K_CNT);
        push(247, K_CLR);
        push(267, K_CLR);
        push(288, K_CNT);
        push(308, K_CNT);
        push(317, K_CLR);
        push(338, K_CNT);
        wait_to(218);
        chk1("resume_2", bus.paused, 1'b0);
        wait_to(220);
        bus.btn_pause = 1'b0;
        wait_to(240);
        bus.btn_reset = 1'b1;
        wait_to(250);
        bus.btn_reset = 1'b0;
        wait_to(260);
        bus.btn_reset = 1'b1;
        wait_to(268);
        chk1("clear_keeps_run", bus.paused, 1'b0);
        wait_to(270);
        bus.btn_reset = 1'b0;
        wait_to(310);
        bus.btn_reset = 1'b1;
        bus.btn_pause = 1'b1;
        wait_to(320);
        bus.btn_reset = 1'b0;
        bus.btn_pause = 1'b0;
        chk1("clear_beats_pause", bus.paused, 1'b0);
        chk1("clear_beats_pause_adj", bus.is_adj, 1'b0);
        wait_to(340);
        bus.sw_adj = 1'b1;
        for (int t = 353; t <= 373; t += 10) push(t, K_ADJ);
        wait_to(375);
        chk1("pre_rst_blink", bus.blink, 1'b1);
        chk1("pre_rst_adj", bus.is_adj, 1'b1);
        rst = 1'b1;
        bus.sw_adj = 1'b0;
        wait_to(376);
        chk8("mid_reset_outs", w_outs, 8'h00);
        rst = 1'b0;
        push(396, K_CNT);
        push(416, K_CNT);
        wait_to(380);
        chk1("post_rst_adj", bus.is_adj, 1'b0);
        chk1("post_rst_paused", bus.paused, 1'b0);
        chk8("post_rst_sel", 8'(bus.adj_sel), 8'h02);
        wait_to(420);
        chk8("queue_drained", 8'(q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control block for the Lab3 stopwatch: debounces the pause and reset buttons, synchronises the adjust switches, and divides the board clock into the 1 Hz count and 2 Hz adjust strobes. It also runs the RUN/PAUSED/ADJUST mode machine. It sits between the board I/O and the minutes/seconds counter. It replaces free-running oneHz/twoHz clocks with single-cycle enables in the `clk` domain, so the counter becomes fully synchronous.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency; must be even and ≥ 4.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a button change is accepted.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_pause`  in  1  raw pause button, asynchronous.
- `btn_reset`  in  1  raw reset button, asynchronous.
- `sw_adj`  in  1  raw adjust-mode switch, asynchronous.
- `sw_sel`  in  2  raw field select, asynchronous; bit1 = minutes, bit0 = seconds.
- `cnt_en`  out  1  one-cycle strobe: counter increments seconds.
- `adj_en`  out  1  one-cycle strobe: counter increments the field(s) selected by `adj_sel`.
- `adj_sel`  out  2  synchronised `sw_sel`.
- `is_adj`  out  1  high while in ADJUST.
- `paused`  out  1  high while in PAUSED.
- `clear`  out  1  one-cycle strobe: counter clears to 00:00.
- `blink`  out  1  display blink level; toggles while in ADJUST.

## Operation
- **Synchronisers.** `sw_adj` and `sw_sel` pass through 2-flop synchronisers only, with no debounce.
- **Debouncers.** Each button passes through a 2-flop synchroniser and then a debouncer.
  - The debounced level updates after `DEBOUNCE_CYCLES` consecutive cycles in which the synchronised input differs from the current stable level.
  - Any cycle in which the input matches the stable level zeroes the debounce count.
  - A rising edge of the debounced level produces a registered one-cycle press pulse.
- **Divider.** Count register `div` runs 0..`CLK_HZ`-1 and wraps.
  - `tick1` fires when `div` = `CLK_HZ`-1.
  - `tick2` fires when `div` = `CLK_HZ`/2-1 or `CLK_HZ`-1.
  - `div` increments only in RUN and ADJUST; it holds in PAUSED.
  - `div` is forced to 0 on every state change and on every `clear`.
- **States.** RUN (reset state), PAUSED, ADJUST. Transitions, in priority order:
  - `sw_adj_s`=1 in RUN or PAUSED → ADJUST.
  - `sw_adj_s`=0 in ADJUST → PAUSED, always.
  - Pause press in RUN → PAUSED; pause press in PAUSED → RUN.
  - Pause press in ADJUST is ignored.
- **Outputs.**
  - `cnt_en` = `tick1` in RUN.
  - `adj_en` = `tick2` in ADJUST.
  - `blink` toggles on each `tick2` in ADJUST and is forced to 0 outside ADJUST.
  - `clear` = reset press pulse, valid in any state. `clear` does not change state.
- **Simultaneous events.**
  - Reset press and pause press in the same cycle: `clear` is emitted, the pause press is discarded, and `div` is zeroed.
  - Adjust switch change and pause press in the same cycle: the adjust transition wins and the press is discarded.
  - `tick1` coincident with `clear`: `cnt_en` is suppressed.
- **Reset.** `rst` mid-operation returns the block to RUN with `div`=0, debouncers stable-low, synchronisers 0, and all outputs 0.

## Timing
- Every output is registered, i.e. driven straight from a flop.
- Reset value of every output is 0. State resets to RUN.
- Button latency: a raw rise held steady gives its press pulse exactly `DEBOUNCE_CYCLES`+3 cycles later. This is 2 cycles of synchroniser, `DEBOUNCE_CYCLES` of filter, and 1 of edge register.
- Switch latency: `is_adj` and `paused` change 3 cycles after a raw `sw_adj` edge. `adj_sel` follows `sw_sel` 2 cycles after an edge.
- Bounces shorter than `DEBOUNCE_CYCLES` produce no pulse.
- First `cnt_en` after reset comes `CLK_HZ` cycles after `rst` deasserts.
- After PAUSED→RUN, the next `cnt_en` comes `CLK_HZ` cycles after the transition cycle, so a resumed stopwatch counts a full second.
- Strobe widths: `cnt_en`, `adj_en` and `clear` are each exactly one cycle wide.
- Strobe spacing: `cnt_en` never fires twice within `CLK_HZ` cycles; `adj_en` never fires twice within `CLK_HZ`/2 cycles.

## Structure
- **Shared package `stopwatch_pkg`:**
  - state encoding constants: RUN=2'd0, PAUSED=2'd1, ADJUST=2'd2;
  - select bit indices: SEL_MIN=1, SEL_SEC=0;
  - the divider width, computed as clog2(`CLK_HZ`).
- **Sub-module `stopwatch_debounce`:** synchroniser, filter and rising-edge pulse, parameterised by `DEBOUNCE_CYCLES`. It is instantiated twice, once for `btn_pause` and once for `btn_reset`.
- **Top level:** the divider, the mode machine and the switch synchronisers stay in `stopwatch_ctrl`.

## Test plan
All scenarios use `CLK_HZ`=20 and `DEBOUNCE_CYCLES`=4.
- **Reset and counting.** Release `rst` with all inputs low → all outputs 0. First `cnt_en` at cycle 20, then every 20 cycles. `adj_en`=`blink`=0 throughout.
- **Debounce.** Pulse `btn_pause` high 3 cycles, low 1, high 3 → no `paused` change. Hold `btn_pause` high → press pulse at cycle 7 after the rise, `paused`=1 the next cycle, `cnt_en` stops. A second press → RUN, next `cnt_en` 20 cycles after the transition.
- **Adjust.** Set `sw_sel`=2'b10, then `sw_adj`=1 → `is_adj`=1 after 3 cycles and `adj_sel`=2'b10. `adj_en` fires every 10 cycles, `blink` toggles with each. Pressing pause → no effect. `sw_adj`=0 → `paused`=1, `blink`=0.
- **Clear priority.** Press reset while running → one-cycle `clear`, `div` restarts, next `cnt_en` 20 cycles later. Pause and reset presses landing in the same cycle → `clear` only, state unchanged.
- **Mid-operation reset.** Assert `rst` for 1 cycle while in ADJUST with `blink`=1 → next cycle all outputs 0, state RUN, first `cnt_en` 20 cycles after release.
